knn_topk_collector: RTL

- Receiving end of the distance stream produced by the KNN distance-compute stage: accepts one knn_entry_t candidate per cycle, with its distance already filled in.
- Keeps a sorted top-K list, nearest first, in a shift-register insertion array.
- Presents the final K nearest neighbours to the next-query logic, with a done pulse when the candidate stream ends.

---
 rtl/knn_topk_collector.sv | 124 ++++++++++++
 1 files changed

// File: rtl/knn_topk_collector.sv
// Top-K nearest-neighbour collector: keeps a sorted insertion list of the K closest candidates.
// Optional feature: define KNN_TOPK_DEDUP_EN to drop candidates whose addr is already in the list.

`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef K
`define K 4
`endif

package knn_pkg;
    localparam int BIT_WIDTH = `BIT_WIDTH;
    localparam int K         = `K;
    localparam int ADDR_W    = 16;

    typedef struct packed {
        logic [BIT_WIDTH-1:0]   x;
        logic [BIT_WIDTH-1:0]   y;
        logic [BIT_WIDTH-1:0]   z;
        logic [ADDR_W-1:0]      addr;
        logic [2*BIT_WIDTH-1:0] distance;
        logic                   valid;
    } knn_entry_t;
endpackage

module knn_topk_collector #(
    parameter int BIT_WIDTH = knn_pkg::BIT_WIDTH,
    parameter int K         = knn_pkg::K
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           cand_valid,
    output logic                           cand_ready,
    input  logic                           cand_last,
    input  knn_pkg::knn_entry_t            cand_in,
    output knn_pkg::knn_entry_t [0:K-1]    knn_out,
    output logic [$clog2(K+1)-1:0]         knn_count,
    output logic                           busy,
    output logic                           done
);
    localparam int CW = $clog2(K+1);
    localparam int DW = 2*BIT_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]                       state_q, state_d;
    knn_pkg::knn_entry_t [0:K-1]      list_q, list_d, ins_list, shifted;
    logic [CW-1:0]                    count_q, count_d;
    logic [K-1:0]                     le, at_p;
    logic [DW-1:0]                    cand_dist;
    logic                             dup, drop;

    assign cand_dist = cand_in.distance;

    // le[] is a contiguous prefix (list is sorted, valid entries packed at the front),
    // so slot i is the insert point exactly when le[i] is clear and le[i-1] is set.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < K; i++) begin
            le[i] = list_q[i].valid && (list_q[i].distance <= cand_dist);
`ifdef KNN_TOPK_DEDUP_EN
            if (list_q[i].valid && (list_q[i].addr == cand_in.addr)) dup = 1'b1;
`endif
        end
        at_p[0]    = 1'b1;
        shifted[0] = '0;
        for (int i = 1; i < K; i++) begin
            at_p[i]    = le[i-1];
            shifted[i] = list_q[i-1];
        end
        for (int i = 0; i < K; i++) begin
            ins_list[i] = le[i] ? list_q[i] : (at_p[i] ? cand_in : shifted[i]);
        end
        drop = !cand_in.valid || le[K-1] || dup;
    end

    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        count_d = count_q;
        if (start) begin
            // Restart wins over any same-cycle transfer or cand_last.
            state_d = S_COLLECT;
            list_d  = '0;
            count_d = '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (cand_valid) begin
                        if (!drop) begin
                            list_d = ins_list;
                            if (count_q != CW'(K)) count_d = count_q + 1'b1;
                        end
                        if (cand_last) state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            list_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            count_q <= count_d;
        end
    end

    assign cand_ready = (state_q == S_COLLECT);
    assign busy       = (state_q == S_COLLECT);
    assign done       = (state_q == S_DONE);
    assign knn_out    = list_q;
    assign knn_count  = count_q;

endmodule
